// File: rtl/reg_wb_arbiter_pkg.sv
// Shared CPU definitions for the register-file writeback path: datapath widths,
// instruction-word field positions and the writeback FSM encoding.
package reg_wb_arbiter_pkg;

  localparam int CPU_DATA_W   = 8;
  localparam int CPU_ADDR_W   = 2;
  localparam int CPU_INST_W   = 16;
  localparam int CPU_DEST_LSB = 10;
  localparam int CPU_DEST_MSB = 11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rr_select2.sv
// Two-way round-robin selector: grants the only valid requester, or the one
// named by the priority pointer when both are valid. i_block suppresses all grants.
module rr_select2 (
  input  logic [1:0] i_valid,
  input  logic       i_block,
  input  logic       i_ptr,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    o_grant = 2'b00;
    if (!i_block) begin
      if (i_valid == 2'b11) begin
        o_grant[i_ptr] = 1'b1;
      end else begin
        o_grant = i_valid;
      end
    end
  end

  assign o_winner = o_grant[1];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port,
// presenting the winner's write as registered rf_en/rf_inst/rf_data for one cycle.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int INST_W = CPU_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_en,
  output logic [INST_W-1:0] rf_inst,
  output logic [DATA_W-1:0] rf_data,
  output logic              last_grant,
  output logic [7:0]        wr_count
);

  wb_state_t         r_state;
  wb_state_t         w_state_next;
  logic              r_ptr;
  logic              r_last;
  logic [7:0]        r_count;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_data;

  logic [1:0]        w_grant;
  logic              w_winner;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [INST_W-1:0] w_inst;

  // Reset blocks grants too, so a write presented during reset is simply dropped.
  rr_select2 u_rr_select2 (
    .i_valid  ({req1_valid, req0_valid}),
    .i_block  (rst | hold),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_accept   = |w_grant;
  assign w_addr     = w_winner ? req1_addr : req0_addr;
  assign w_data     = w_winner ? req1_data : req0_data;

  always_comb begin
    w_inst = '0;
    w_inst[CPU_DEST_LSB +: ADDR_W] = w_addr;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    if (w_accept) begin
      w_state_next = ST_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= '0;
      r_data  <= '0;
      r_ptr   <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_inst <= w_inst;
      r_data <= w_data;
      r_ptr  <= ~w_winner;
      r_last <= w_winner;
      if (r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign rf_en      = (r_state == ST_WRITE);
  assign rf_inst    = r_inst;
  assign rf_data    = r_data;
  assign last_grant = r_last;
  assign wr_count   = r_count;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, saturation run
// and randomized traffic compared against a rule-level reference model.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        req0_valid;
  logic [1:0]  req0_addr;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [1:0]  req1_addr;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        rf_en;
  logic [15:0] rf_inst;
  logic [7:0]  rf_data;
  logic        last_grant;
  logic [7:0]  wr_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_en = 1'b0;
  logic [15:0] m_inst = '0;
  logic [7:0]  m_data = '0;
  int          m_lg = 0;
  logic [7:0]  sh_rf [4];

  typedef struct {
    bit          rst;
    bit          hold;
    bit          v0;
    logic [1:0]  a0;
    logic [7:0]  d0;
    bit          v1;
    logic [1:0]  a1;
    logic [7:0]  d1;
    bit          er0;
    bit          er1;
    bit          een;
    logic [15:0] einst;
    logic [7:0]  edata;
    bit          elg;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl [20];

  reg_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_en      (rf_en),
    .rf_inst    (rf_inst),
    .rf_data    (rf_data),
    .last_grant (last_grant),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit h, input bit v0, input logic [1:0] a0,
                       input logic [7:0] d0, input bit v1, input logic [1:0] a1,
                       input logic [7:0] d1);
    rst        = r;
    hold       = h;
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
  endtask

  // Which requester the rules say is accepted this cycle (-1 = none).
  function automatic int pick();
    if (rst || hold) return -1;
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_update(input int w);
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_en = 1'b0; m_inst = '0; m_data = '0; m_lg = 0;
    end else if (w >= 0) begin
      m_en   = 1'b1;
      m_inst = 16'((w == 1 ? int'(req1_addr) : int'(req0_addr)) * 1024);
      m_data = (w == 1) ? req1_data : req0_data;
      m_lg   = w;
      m_ptr  = 1 - w;
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
    end else begin
      m_en = 1'b0;
    end
  endtask

  task automatic shadow_update();
    if (rf_en) sh_rf[rf_inst[11:10]] = rf_data;
  endtask

  // One model-checked cycle; inputs already driven just after a falling edge.
  task automatic model_cycle();
    int w;
    #1;
    w = pick();
    check("ready0", {31'd0, req0_ready}, {31'd0, w == 0});
    check("ready1", {31'd0, req1_ready}, {31'd0, w == 1});
    model_update(w);
    @(posedge clk);
    @(negedge clk);
    shadow_update();
    check("rf_en", {31'd0, rf_en}, {31'd0, m_en});
    check("rf_inst", {16'd0, rf_inst}, {16'd0, m_inst});
    check("rf_data", {24'd0, rf_data}, {24'd0, m_data});
    check("last_grant", {31'd0, last_grant}, m_lg);
    check("wr_count", {24'd0, wr_count}, m_cnt);
  endtask

  initial begin
    int w;
    foreach (sh_rf[k]) sh_rf[k] = '0;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0800, 8'h5A, 1'b0, 8'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0800, 8'h5A, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b1, 1'b0, 1'b1, 16'h0400, 8'h11, 1'b0, 8'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b1, 1'b1, 16'h0C00, 8'h33, 1'b1, 8'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b1, 1'b0, 1'b1, 16'h0400, 8'h11, 1'b0, 8'd3};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 1'b1, 1'b1, 16'h0C00, 8'h33, 1'b1, 8'd4};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0C00, 8'h33, 1'b1, 8'd4};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h77, 1'b0, 1'b0, 1'b0, 16'h0C00, 8'h33, 1'b1, 8'd4};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h77, 1'b0, 1'b0, 1'b0, 16'h0C00, 8'h33, 1'b1, 8'd4};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h77, 1'b0, 1'b0, 1'b0, 16'h0C00, 8'h33, 1'b1, 8'd4};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h77, 1'b0, 1'b1, 1'b1, 16'h0800, 8'h77, 1'b1, 8'd5};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 8'hBB, 1'b1, 1'b0, 1'b1, 16'h0000, 8'hAA, 1'b0, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hBB, 1'b0, 1'b1, 1'b1, 16'h0000, 8'hBB, 1'b1, 8'd2};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h42, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0400, 8'h42, 1'b0, 8'd3};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h99, 1'b1, 2'd3, 8'h55, 1'b1, 1'b0, 1'b1, 16'h0800, 8'h99, 1'b0, 8'd1};

    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    @(negedge clk);

    // Directed vectors: reset, single write, contention, hold, same address, reset mid-run
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].v0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].a1, tbl[i].d1);
      #1;
      check($sformatf("vec%0d ready0", i), {31'd0, req0_ready}, {31'd0, tbl[i].er0});
      check($sformatf("vec%0d ready1", i), {31'd0, req1_ready}, {31'd0, tbl[i].er1});
      w = pick();
      model_update(w);
      @(posedge clk);
      @(negedge clk);
      shadow_update();
      check($sformatf("vec%0d rf_en", i), {31'd0, rf_en}, {31'd0, tbl[i].een});
      check($sformatf("vec%0d rf_inst", i), {16'd0, rf_inst}, {16'd0, tbl[i].einst});
      check($sformatf("vec%0d rf_data", i), {24'd0, rf_data}, {24'd0, tbl[i].edata});
      check($sformatf("vec%0d last_grant", i), {31'd0, last_grant}, {31'd0, tbl[i].elg});
      check($sformatf("vec%0d wr_count", i), {24'd0, wr_count}, {24'd0, tbl[i].ecnt});
      if (i == 15) check("same_addr_first R0", {24'd0, sh_rf[0]}, 32'h0000_00AA);
      if (i == 16) check("same_addr_final R0", {24'd0, sh_rf[0]}, 32'h0000_00BB);
    end

    // Saturation: 300 back-to-back accepted writes from requester 0
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0, 2'd0, 8'h00);
      model_cycle();
    end
    check("wr_count saturated", {24'd0, wr_count}, 32'd255);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of write data.
REQ-002 Parameter ADDR_W, default 2: width of the destination register index.
REQ-003 Parameter INST_W, default 16: width of the instruction-format word driven to the register file.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 hold  input  1  when 1, no new grants are issued.
REQ-007 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-008 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-009 req0_data  input  DATA_W  requester 0 write data.
REQ-010 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-011 req1_valid, req1_addr, req1_data, req1_ready: same directions, widths and meanings for requester 1 (load writeback).
REQ-012 rf_en  output  1  register-file write enable, registered.
REQ-013 rf_inst  output  INST_W  bits [11:10] = destination index; all other bits 0; registered.
REQ-014 rf_data  output  DATA_W  register-file write data, registered.
REQ-015 last_grant  output  1  index of the most recently accepted requester.
REQ-016 wr_count  output  8  saturating count of accepted writes.

Function
REQ-017 A handshake completes on a rising edge where reqN_valid=1 and reqN_ready=1.
REQ-018 reqN_ready is combinational from valid, hold and the priority pointer; at most one ready is 1 per cycle.
REQ-019 hold=1 forces both ready signals to 0.
REQ-020 Only one requester valid and hold=0: that requester gets ready=1.
REQ-021 Both valid and hold=0: the requester named by the priority pointer wins.
REQ-022 After every accepted write, the priority pointer changes to the non-winning index (round robin); with no acceptance it holds.
REQ-023 Latency: a write accepted at edge N drives rf_en=1, rf_inst[11:10]=addr and rf_data=data from edge N until edge N+1, so it is stable at the register file's falling-edge write.
REQ-024 With no acceptance at an edge, rf_en=0 after that edge; rf_inst and rf_data hold their previous values.
REQ-025 Back-to-back acceptances produce rf_en=1 on consecutive cycles with no bubble.
REQ-026 Two requests to the same address are serialized in grant order; the later-granted data is the final register content.
REQ-027 A losing requester keeps valid, addr and data stable until it is accepted; the block does not check this.
REQ-028 Each acceptance increments wr_count by 1; it saturates at 255.
REQ-029 The FSM states are IDLE (rf_en=0) and WRITE (rf_en=1); an acceptance moves to WRITE, otherwise to IDLE.

Reset
REQ-030 rst=1 at a rising edge forces IDLE, rf_en=0, rf_inst=0, rf_data=0, the priority pointer to 0, last_grant=0 and wr_count=0.
REQ-031 While rst=1, both ready signals are 0; a write in flight is dropped and the register file is not written.
REQ-032 Priority after reset: requester 0 wins the first contended cycle.

Structure
REQ-033 DATA_W, ADDR_W, INST_W, the destination-field position (bits 11:10) and the FSM state encoding belong in a shared CPU package.
REQ-034 The round-robin selector is a natural sub-module: rr_select2.

Verification
REQ-035 Reset: assert rst for 2 cycles with both valid -> both ready=0, rf_en=0, wr_count=0, last_grant=0.
REQ-036 Single requester: req0 writes addr=2, data=0x5A -> the next cycle has rf_en=1, rf_inst=0x0800, rf_data=0x5A, and wr_count=1.
REQ-037 Contention: both valid for 4 cycles (req0 addr=1/0x11, req1 addr=3/0x33) -> grants alternate 0,1,0,1, rf_en=1 on all 4 following cycles, last_grant tracks each winner.
REQ-038 Same address: req0 addr=0/0xAA and req1 addr=0/0xBB together after reset -> 0xAA is written first, then 0xBB; the final R0 is 0xBB.
REQ-039 Hold: hold=1 for 3 cycles with req1 valid -> no ready and rf_en=0; releasing hold gives req1 ready in the first cycle.
REQ-040 Reset mid-operation and saturation: rst on the edge after an acceptance -> rf_en=0 and the pointer is 0; 300 accepted writes -> wr_count=255.
